// File: rtl/tape_mem.sv
// tape_mem: responder for the core's tape-memory port.
// Sweeps the tape to zero after reset or on request, then serves reads/writes.
module tape_mem #(
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 65536
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              tape_we,
    input  logic [ADDR_W-1:0] tape_addr,
    input  logic [7:0]        tape_data_write,
    output logic [7:0]        tape_data_read,
    input  logic              clear_req,
    output logic              ready,
    output logic              drop_err
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(DEPTH - 1);

    typedef enum logic {
        CLEAR = 1'b0,
        SERVE = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic [7:0]       rd_q, rd_d;
    logic             ready_q, ready_d;
    logic             drop_q, drop_d;

    logic [7:0]       mem [DEPTH];
    logic [IDX_W-1:0] idx;
    logic             mem_we;
    logic [IDX_W-1:0] mem_addr;
    logic [7:0]       mem_wdata;

    // Upper address bits are ignored so addresses wrap modulo DEPTH.
    assign idx = tape_addr[IDX_W-1:0];

    generate
        if (ADDR_W > IDX_W) begin : g_hi
            logic unused_hi;
            assign unused_hi = ^tape_addr[ADDR_W-1:IDX_W];
        end
    endgenerate

    // Next state, sweep counter, array port and registered outputs.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rd_d      = rd_q;
        ready_d   = ready_q;
        drop_d    = drop_q;
        mem_we    = 1'b0;
        mem_addr  = idx;
        mem_wdata = tape_data_write;
        unique case (state_q)
            CLEAR: begin
                mem_we    = 1'b1;
                mem_addr  = cnt_q;
                mem_wdata = 8'h00;
                rd_d      = 8'h00;
                if (tape_we) drop_d = 1'b1;
                if (clear_req) begin
                    cnt_d = '0;
                end else if (cnt_q == LAST) begin
                    state_d = SERVE;
                    ready_d = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + IDX_W'(1);
                end
            end
            SERVE: begin
                mem_we = tape_we;
                rd_d   = tape_we ? tape_data_write : mem[idx];
                if (clear_req) begin
                    state_d = CLEAR;
                    ready_d = 1'b0;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = CLEAR;
                ready_d = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

    // Control and output registers, asynchronously returned to the sweep.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
            rd_q    <= 8'h00;
            ready_q <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            ready_q <= ready_d;
            drop_q  <= drop_d;
        end
    end

    // Tape array; never reset, the sweep zeroes it instead.
    always_ff @(posedge clock) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
    end

    assign tape_data_read = rd_q;
    assign ready          = ready_q;
    assign drop_err       = drop_q;

endmodule

// File: tb/tb_tape_mem.sv
// tb_tape_mem: directed plus random stimulus for tape_mem (DEPTH=16),
// checked against an abstract tape model.
module tb_tape_mem;
    localparam int ADDR_W = 16;
    localparam int DEPTH  = 16;

    logic              clock = 1'b0;
    logic              reset_n = 1'b0;
    logic              tape_we = 1'b0;
    logic [ADDR_W-1:0] tape_addr = '0;
    logic [7:0]        tape_data_write = '0;
    logic [7:0]        tape_data_read;
    logic              clear_req = 1'b0;
    logic              ready;
    logic              drop_err;

    int n_checks = 0;
    int n_errors = 0;

    // Abstract model: tape contents, serving flag, posedges spent sweeping.
    logic [7:0] m_tape [DEPTH];
    bit         m_serving;
    int         m_elapsed;
    bit         m_drop;
    logic [7:0] m_rd;

    tape_mem #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clock(clock),
        .reset_n(reset_n),
        .tape_we(tape_we),
        .tape_addr(tape_addr),
        .tape_data_write(tape_data_write),
        .tape_data_read(tape_data_read),
        .clear_req(clear_req),
        .ready(ready),
        .drop_err(drop_err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [7:0] got,
                       input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp,
                     $time);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".ready"}, {7'd0, ready}, {7'd0, m_serving});
        chk({tag, ".drop"}, {7'd0, drop_err}, {7'd0, m_drop});
        chk({tag, ".rd"}, tape_data_read, m_rd);
    endtask

    task automatic model_reset();
        m_serving = 1'b0;
        m_elapsed = 0;
        m_drop    = 1'b0;
        m_rd      = 8'h00;
    endtask

    // One clock: apply inputs, advance the model, check after the edge.
    task automatic step(input bit we, input logic [ADDR_W-1:0] addr,
                        input logic [7:0] data, input bit clr,
                        input string tag);
        int i;
        tape_we         = we;
        tape_addr       = addr;
        tape_data_write = data;
        clear_req       = clr;
        @(posedge clock);
        i = int'(addr) % DEPTH;
        if (!m_serving) begin
            m_rd = 8'h00;
            if (we) m_drop = 1'b1;
            if (clr) begin
                m_elapsed = 0;
            end else begin
                m_elapsed++;
                if (m_elapsed == DEPTH) begin
                    m_serving = 1'b1;
                    for (int k = 0; k < DEPTH; k++) m_tape[k] = 8'h00;
                end
            end
        end else begin
            m_rd = we ? data : m_tape[i];
            if (we) m_tape[i] = data;
            if (clr) begin
                m_serving = 1'b0;
                m_elapsed = 0;
            end
        end
        #1;
        check_all(tag);
    endtask

    task automatic idle(input int n, input string tag);
        for (int k = 0; k < n; k++) step(0, '0, 8'h00, 0, tag);
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic pulse_reset(input string tag);
        tape_we   = 1'b0;
        clear_req = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        model_reset();
        #3;
        check_all("rst");
        @(posedge clock);
        #1;
        reset_n = 1'b1;

        idle(DEPTH - 1, "sweep0");
        chk("sweep0.not_yet", {7'd0, ready}, 8'h00);
        idle(1, "sweep0.end");
        chk("sweep0.ready", {7'd0, ready}, 8'h01);

        step(1, 16'd5, 8'hAA, 0, "pre5");
        pulse_reset("rst2");
        idle(DEPTH, "sweep1");
        step(0, 16'd5, 8'h00, 0, "rd5");
        chk("rd5.zero", tape_data_read, 8'h00);

        step(1, 16'd3, 8'h42, 0, "wr3");
        step(0, 16'd3, 8'h00, 0, "rd3");
        chk("rd3.val", tape_data_read, 8'h42);
        step(0, 16'd4, 8'h00, 0, "rd4");
        chk("rd4.val", tape_data_read, 8'h00);

        step(1, 16'd7, 8'h99, 0, "byp7");
        chk("byp7.val", tape_data_read, 8'h99);
        step(0, 16'd7, 8'h00, 0, "rd7");
        chk("rd7.val", tape_data_read, 8'h99);

        step(1, 16'h0013, 8'h11, 0, "wrap.wr");
        step(0, 16'h0003, 8'h00, 0, "wrap.rd3");
        chk("wrap.rd3.val", tape_data_read, 8'h11);
        step(0, 16'hFFF3, 8'h00, 0, "wrap.rdF");
        chk("wrap.rdF.val", tape_data_read, 8'h11);

        step(1, 16'd2, 8'h55, 1, "clr");
        chk("clr.ready", {7'd0, ready}, 8'h00);
        step(1, 16'd9, 8'h77, 0, "drop");
        chk("drop.flag", {7'd0, drop_err}, 8'h01);
        idle(DEPTH - 1, "sweep2");
        chk("sweep2.ready", {7'd0, ready}, 8'h01);
        step(0, 16'd2, 8'h00, 0, "rd2");
        chk("rd2.zero", tape_data_read, 8'h00);
        chk("rd2.drop", {7'd0, drop_err}, 8'h01);

        step(0, '0, 8'h00, 1, "rs.clr");
        idle(9, "rs.a");
        step(0, '0, 8'h00, 1, "rs.clr10");
        idle(DEPTH - 1, "rs.b");
        chk("rs.not_yet", {7'd0, ready}, 8'h00);
        idle(1, "rs.end");
        chk("rs.ready", {7'd0, ready}, 8'h01);

        step(1, 16'd1, 8'h01, 1, "mr.clr");
        idle(5, "mr.a");
        pulse_reset("mr.rst");
        chk("mr.drop", {7'd0, drop_err}, 8'h00);
        idle(DEPTH - 1, "mr.b");
        chk("mr.not_yet", {7'd0, ready}, 8'h00);
        idle(1, "mr.end");
        chk("mr.ready", {7'd0, ready}, 8'h01);

        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 299) == 0) begin
                pulse_reset("rnd.rst");
            end else begin
                step(1'($urandom_range(0, 1)),
                     ($urandom_range(0, 3) == 0) ?
                         16'($urandom) : 16'($urandom_range(0, DEPTH - 1)),
                     8'($urandom),
                     $urandom_range(0, 59) == 0, "rnd");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
